switch_alloc: RTL and testbench

Switch allocator for the 5-port mesh router. Each input queue head presents a valid flit plus the 3-bit output-port code from its route computation. The block grants each output port to one input at a time, with round-robin fairness. It holds the grant (wormhole lock) from head flit to tail flit and drives the crossbar select and queue pop strobes.

---
 rtl/switch_alloc_if.sv | 22 ++
 rtl/switch_alloc.sv | 135 +++++++++++++
 tb/tb_switch_alloc.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_alloc_if.sv
// Allocator-facing bundle: queue-head request signals in, crossbar select and pop strobes out.
interface switch_alloc_if;
  logic [4:0]  in_valid_i;
  logic [14:0] in_dest_i;
  logic [4:0]  in_tail_i;
  logic [4:0]  out_ready_i;
  logic [4:0]  in_pop_o;
  logic [4:0]  out_valid_o;
  logic [14:0] out_sel_o;
  logic [4:0]  out_busy_o;
  logic        wdog_err_o;

  modport master (
    output in_valid_i, in_dest_i, in_tail_i, out_ready_i,
    input  in_pop_o, out_valid_o, out_sel_o, out_busy_o, wdog_err_o
  );

  modport slave (
    input  in_valid_i, in_dest_i, in_tail_i, out_ready_i,
    output in_pop_o, out_valid_o, out_sel_o, out_busy_o, wdog_err_o
  );
endinterface

// File: rtl/switch_alloc.sv
// Round-robin wormhole switch allocator: 1-cycle grant bubble, transfers combinational while locked,
// lock held through out_ready stalls; SA_WATCHDOG_EN adds a stall watchdog that frees hung locks.
module switch_alloc #(
  parameter int NPORTS      = 5,
  parameter int WDOG_CYCLES = 255
) (
  input logic           clk_i,
  input logic           rst_i,
  switch_alloc_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state  [NPORTS];
  logic [2:0]        owner  [NPORTS];
  logic [2:0]        rr_ptr [NPORTS];
  logic [2:0]        grant  [NPORTS];
  logic [NPORTS-1:0] req    [NPORTS];
  logic [NPORTS-1:0] grant_vld, owned, xfer, xfer_tail, wdog_rel;
  logic [NPORTS-1:0] pop, busy;
  logic [3*NPORTS-1:0] sel;

  // An input already holding a lock may not compete for another output.
  always_comb begin
    owned = '0;
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        if (state[o] == BUSY && owner[o] == 3'(i)) owned[i] = 1'b1;
  end

  always_comb begin
    logic [3:0] idx;
    logic       cur_vld, cur_tail;
    logic [2:0] cur_dest;
    idx       = '0;
    cur_vld   = 1'b0;
    cur_tail  = 1'b0;
    cur_dest  = '0;
    grant_vld = '0;
    xfer      = '0;
    xfer_tail = '0;
    pop       = '0;
    busy      = '0;
    sel       = '0;
    for (int o = 0; o < NPORTS; o++) begin
      grant[o] = '0;
      req[o]   = '0;
      for (int i = 0; i < NPORTS; i++)
        req[o][i] = bus.in_valid_i[i] && (bus.in_dest_i[3*i +: 3] == 3'(o)) && !owned[i];
      for (int k = 0; k < NPORTS; k++) begin
        idx = {1'b0, rr_ptr[o]} + 4'(k);
        if (idx >= 4'(NPORTS)) idx = idx - 4'(NPORTS);
        if (!grant_vld[o] && req[o][idx[2:0]]) begin
          grant_vld[o] = 1'b1;
          grant[o]     = idx[2:0];
        end
      end
      cur_vld  = 1'b0;
      cur_tail = 1'b0;
      cur_dest = '0;
      for (int i = 0; i < NPORTS; i++)
        if (owner[o] == 3'(i)) begin
          cur_vld  = bus.in_valid_i[i];
          cur_tail = bus.in_tail_i[i];
          cur_dest = bus.in_dest_i[3*i +: 3];
        end
      if (state[o] == BUSY) begin
        busy[o]        = 1'b1;
        sel[3*o +: 3]  = owner[o];
        xfer[o]        = cur_vld && (cur_dest == 3'(o)) && bus.out_ready_i[o];
        xfer_tail[o]   = xfer[o] && cur_tail;
        for (int i = 0; i < NPORTS; i++)
          if (owner[o] == 3'(i) && xfer[o]) pop[i] = 1'b1;
      end
    end
  end

`ifdef SA_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] stall_cnt [NPORTS];
  logic          wdog_err;

  // Release fires on the stall cycle that brings the count up to WDOG_CYCLES.
  always_comb begin
    wdog_rel = '0;
    for (int o = 0; o < NPORTS; o++)
      wdog_rel[o] = (state[o] == BUSY) && !xfer[o] && (stall_cnt[o] == CW'(WDOG_CYCLES - 1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wdog_err <= 1'b0;
      for (int o = 0; o < NPORTS; o++) stall_cnt[o] <= '0;
    end else begin
      wdog_err <= |wdog_rel;
      for (int o = 0; o < NPORTS; o++)
        if (state[o] != BUSY || xfer[o]) stall_cnt[o] <= '0;
        else stall_cnt[o] <= stall_cnt[o] + 1'b1;
    end
  end

  assign bus.wdog_err_o = wdog_err;
`else
  assign wdog_rel       = '0;
  assign bus.wdog_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int o = 0; o < NPORTS; o++) begin
        state[o]  <= IDLE;
        owner[o]  <= '0;
        rr_ptr[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        case (state[o])
          IDLE: if (grant_vld[o]) begin
            owner[o] <= grant[o];
            state[o] <= BUSY;
          end
          BUSY: if (xfer_tail[o] || wdog_rel[o]) begin
            state[o]  <= IDLE;
            rr_ptr[o] <= (owner[o] == 3'(NPORTS - 1)) ? 3'd0 : owner[o] + 3'd1;
          end
          default: state[o] <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_pop_o    = pop;
  assign bus.out_valid_o = xfer;
  assign bus.out_sel_o   = sel;
  assign bus.out_busy_o  = busy;
endmodule

// File: tb/tb_switch_alloc.sv
// Directed bench for switch_alloc; builds with or without SA_WATCHDOG_EN.
module tb_switch_alloc;
`ifdef SA_WATCHDOG_EN
  localparam int WD    = 8;
  localparam int STALL = 5;
`else
  localparam int WD    = 255;
  localparam int STALL = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  switch_alloc_if bus ();

  switch_alloc #(.NPORTS(5), .WDOG_CYCLES(WD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_q(input int q, input logic v, input logic [2:0] d, input logic t);
    bus.in_valid_i[q]      = v;
    bus.in_dest_i[3*q +: 3] = d;
    bus.in_tail_i[q]       = t;
  endtask

  task automatic do_reset();
    bus.in_valid_i  = '0;
    bus.in_dest_i   = '0;
    bus.in_tail_i   = '0;
    bus.out_ready_i = 5'b11111;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.out_busy_o !== 5'b0 || bus.out_valid_o !== 5'b0 || bus.in_pop_o !== 5'b0 ||
        bus.out_sel_o !== 15'b0 || bus.wdog_err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset: busy=%b valid=%b pop=%b sel=%h wdog=%b, want all 0",
               bus.out_busy_o, bus.out_valid_o, bus.in_pop_o, bus.out_sel_o, bus.wdog_err_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_q(0, 1'b1, 3'd3, 1'b1);
    #1;
    total++;
    if (bus.out_busy_o !== 5'b0 || bus.in_pop_o !== 5'b0) begin
      bad++;
      $display("FAIL single_arb: busy=%b pop=%b, want 0 0", bus.out_busy_o, bus.in_pop_o);
    end
    tick();
    total++;
    if (bus.out_busy_o !== 5'b01000 || bus.out_valid_o !== 5'b01000 ||
        bus.out_sel_o[11:9] !== 3'd0 || bus.in_pop_o !== 5'b00001) begin
      bad++;
      $display("FAIL single_xfer: busy=%b valid=%b sel3=%0d pop=%b, want 01000 01000 0 00001",
               bus.out_busy_o, bus.out_valid_o, bus.out_sel_o[11:9], bus.in_pop_o);
    end
    tick();
    set_q(0, 1'b0, 3'd3, 1'b1);
    #1;
    total++;
    if (bus.out_busy_o !== 5'b0) begin
      bad++;
      $display("FAIL single_release: busy=%b, want 00000", bus.out_busy_o);
    end
  endtask

  task automatic test_round_robin();
    int exp_q [4] = '{1, 2, 4, 1};
    do_reset();
    set_q(1, 1'b1, 3'd4, 1'b1);
    set_q(2, 1'b1, 3'd4, 1'b1);
    set_q(4, 1'b1, 3'd4, 1'b1);
    #1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (bus.out_busy_o[4] !== 1'b0 || bus.in_pop_o !== 5'b0) begin
        bad++;
        $display("FAIL rr_bubble[%0d]: busy4=%b pop=%b, want 0 00000", k, bus.out_busy_o[4], bus.in_pop_o);
      end
      tick();
      total++;
      if (bus.out_sel_o[14:12] !== 3'(exp_q[k]) || bus.in_pop_o !== 5'(1 << exp_q[k]) ||
          bus.out_valid_o !== 5'b10000) begin
        bad++;
        $display("FAIL rr_grant[%0d]: sel4=%0d pop=%b valid=%b, want %0d %b 10000",
                 k, bus.out_sel_o[14:12], bus.in_pop_o, bus.out_valid_o, exp_q[k], 5'(1 << exp_q[k]));
      end
      tick();
    end
  endtask

  task automatic test_wormhole();
    do_reset();
    set_q(0, 1'b1, 3'd2, 1'b0);
    set_q(1, 1'b1, 3'd2, 1'b1);
    tick();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) begin
        bus.in_tail_i[0] = 1'b1;
        #1;
      end
      total++;
      if (bus.in_pop_o !== 5'b00001 || bus.out_sel_o[8:6] !== 3'd0) begin
        bad++;
        $display("FAIL worm_flit[%0d]: pop=%b sel2=%0d, want 00001 0", f, bus.in_pop_o, bus.out_sel_o[8:6]);
      end
      tick();
    end
    set_q(0, 1'b0, 3'd2, 1'b0);
    #1;
    total++;
    if (bus.out_busy_o[2] !== 1'b0 || bus.in_pop_o !== 5'b0) begin
      bad++;
      $display("FAIL worm_gap: busy2=%b pop=%b, want 0 00000", bus.out_busy_o[2], bus.in_pop_o);
    end
    tick();
    total++;
    if (bus.out_sel_o[8:6] !== 3'd1 || bus.in_pop_o !== 5'b00010) begin
      bad++;
      $display("FAIL worm_next: sel2=%0d pop=%b, want 1 00010", bus.out_sel_o[8:6], bus.in_pop_o);
    end
    tick();
  endtask

  task automatic test_parallel();
    do_reset();
    set_q(0, 1'b1, 3'd1, 1'b1);
    set_q(3, 1'b1, 3'd0, 1'b1);
    tick();
    total++;
    if (bus.out_busy_o !== 5'b00011 || bus.out_valid_o !== 5'b00011 || bus.in_pop_o !== 5'b01001 ||
        bus.out_sel_o[2:0] !== 3'd3 || bus.out_sel_o[5:3] !== 3'd0) begin
      bad++;
      $display("FAIL parallel: busy=%b valid=%b pop=%b sel=%h, want 00011 00011 01001 sel0=3 sel1=0",
               bus.out_busy_o, bus.out_valid_o, bus.in_pop_o, bus.out_sel_o);
    end
    tick();
    bus.in_valid_i = '0;
    #1;
    total++;
    if (bus.out_busy_o !== 5'b0) begin
      bad++;
      $display("FAIL parallel_release: busy=%b, want 00000", bus.out_busy_o);
    end
  endtask

  task automatic test_stall_illegal();
    do_reset();
    bus.out_ready_i = 5'b10111;
    set_q(1, 1'b1, 3'd3, 1'b1);
    set_q(2, 1'b1, 3'd6, 1'b1);
    set_q(4, 1'b1, 3'd0, 1'b1);
    tick();
    total++;
    if (bus.out_busy_o !== 5'b01001 || bus.in_pop_o !== 5'b10000 || bus.out_valid_o !== 5'b00001) begin
      bad++;
      $display("FAIL stall_first: busy=%b pop=%b valid=%b, want 01001 10000 00001",
               bus.out_busy_o, bus.in_pop_o, bus.out_valid_o);
    end
    tick();
    set_q(4, 1'b0, 3'd0, 1'b1);
    #1;
    for (int c = 1; c < STALL; c++) begin
      total++;
      if (bus.in_pop_o !== 5'b0 || bus.out_valid_o !== 5'b0 || bus.out_busy_o !== 5'b01000) begin
        bad++;
        $display("FAIL stall_hold[%0d]: pop=%b valid=%b busy=%b, want 0 0 01000",
                 c, bus.in_pop_o, bus.out_valid_o, bus.out_busy_o);
      end
      if (c < STALL - 1) tick();
    end
    bus.out_ready_i = 5'b11111;
    #1;
    total++;
    if (bus.in_pop_o !== 5'b00010 || bus.out_valid_o !== 5'b01000) begin
      bad++;
      $display("FAIL stall_resume: pop=%b valid=%b, want 00010 01000", bus.in_pop_o, bus.out_valid_o);
    end
    tick();
    set_q(1, 1'b0, 3'd3, 1'b1);
    #1;
    total++;
    if (bus.out_busy_o !== 5'b0 || bus.in_pop_o !== 5'b0) begin
      bad++;
      $display("FAIL illegal_dest: busy=%b pop=%b, want 00000 00000", bus.out_busy_o, bus.in_pop_o);
    end
  endtask

`ifdef SA_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    set_q(0, 1'b1, 3'd0, 1'b0);
    tick();
    tick();
    set_q(0, 1'b0, 3'd0, 1'b0);
    set_q(2, 1'b1, 3'd0, 1'b1);
    #1;
    for (int c = 1; c < WD; c++) begin
      tick();
      total++;
      if (bus.out_busy_o[0] !== 1'b1 || bus.wdog_err_o !== 1'b0 || bus.in_pop_o !== 5'b0) begin
        bad++;
        $display("FAIL wdog_hold[%0d]: busy0=%b err=%b pop=%b, want 1 0 00000",
                 c, bus.out_busy_o[0], bus.wdog_err_o, bus.in_pop_o);
      end
    end
    tick();
    total++;
    if (bus.out_busy_o[0] !== 1'b0 || bus.wdog_err_o !== 1'b1) begin
      bad++;
      $display("FAIL wdog_fire: busy0=%b err=%b, want 0 1", bus.out_busy_o[0], bus.wdog_err_o);
    end
    tick();
    total++;
    if (bus.wdog_err_o !== 1'b0 || bus.out_sel_o[2:0] !== 3'd2 || bus.in_pop_o !== 5'b00100) begin
      bad++;
      $display("FAIL wdog_regrant: err=%b sel0=%0d pop=%b, want 0 2 00100",
               bus.wdog_err_o, bus.out_sel_o[2:0], bus.in_pop_o);
    end
    tick();
    set_q(2, 1'b0, 3'd0, 1'b1);
  endtask
`else
  task automatic test_lock_hold();
    do_reset();
    set_q(0, 1'b1, 3'd0, 1'b0);
    tick();
    tick();
    set_q(0, 1'b0, 3'd0, 1'b0);
    set_q(2, 1'b1, 3'd0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      tick();
      total++;
      if (bus.out_busy_o[0] !== 1'b1 || bus.out_sel_o[2:0] !== 3'd0 || bus.wdog_err_o !== 1'b0) begin
        bad++;
        $display("FAIL lock_hold[%0d]: busy0=%b sel0=%0d err=%b, want 1 0 0",
                 c, bus.out_busy_o[0], bus.out_sel_o[2:0], bus.wdog_err_o);
      end
    end
    set_q(2, 1'b0, 3'd0, 1'b1);
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    set_q(0, 1'b1, 3'd2, 1'b0);
    set_q(3, 1'b1, 3'd4, 1'b0);
    tick();
    total++;
    if (bus.out_busy_o !== 5'b10100) begin
      bad++;
      $display("FAIL midreset_lock: busy=%b, want 10100", bus.out_busy_o);
    end
    rst = 1'b1;
    tick();
    total++;
    if (bus.out_busy_o !== 5'b0 || bus.in_pop_o !== 5'b0 || bus.out_valid_o !== 5'b0) begin
      bad++;
      $display("FAIL midreset_clear: busy=%b pop=%b valid=%b, want all 0",
               bus.out_busy_o, bus.in_pop_o, bus.out_valid_o);
    end
    rst = 1'b0;
    bus.in_valid_i = '0;
  endtask

  initial begin
    bus.in_valid_i  = '0;
    bus.in_dest_i   = '0;
    bus.in_tail_i   = '0;
    bus.out_ready_i = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wormhole();
    test_parallel();
    test_stall_illegal();
`ifdef SA_WATCHDOG_EN
    test_watchdog();
`else
    test_lock_hold();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
